button_conditioner: RTL and testbench
=====================================

# button_conditioner

Input front end for the goose game: takes the raw asynchronous jump and halt push-buttons from `ui_in[1:0]` and produces clean, debounced levels plus single-cycle press/release strobes. It sits directly upstream of the game controller, jump physics and RNG inputs in `tt_um_goose_game`, replacing their direct use of the raw pins. Two identical channels are built: channel 0 is jump and channel 1 is halt. An optional long-press detector on the halt channel is also provided.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: number of consecutive stable synchronized samples required to accept a new level (10 ms at 25 MHz); legal range 1 to 2^20-1.
- `LONG_CYCLES`, default 25000000: cycles the halt channel must stay debounced-high before `long_press` fires (1 s at 25 MHz); legal range 1 to 2^25-1.

Ports:
- `clk`  in  1  system clock (pixel clock domain).
- `rst_n`  in  1  reset; synchronous, active-low.
- `btn_raw`  in  2  raw asynchronous buttons; [0]=jump, [1]=halt.
- `btn_level`  out  2  debounced level per channel.
- `btn_rise`  out  2  one-cycle pulse when `btn_level` goes 0→1.
- `btn_fall`  out  2  one-cycle pulse when `btn_level` goes 1→0.
- `long_press`  out  1  one-cycle pulse when halt has been held `LONG_CYCLES` cycles.

## Operation
- Each channel passes through a 2-FF synchronizer: `s1`, then `s2`. Only `s2` is used downstream.
- Each channel runs a per-channel FSM with counter `cnt`, 20 bits wide:
  - RELEASED (`btn_level`=0): if `s2`=1, go to PRESS_WAIT and set `cnt`←1.
  - PRESS_WAIT: if `s2`=0, return to RELEASED with no strobes. If `s2`=1 and `cnt`==`DEBOUNCE_CYCLES`, go to PRESSED, set `btn_level`←1 and pulse `btn_rise`. Otherwise increment `cnt`.
  - PRESSED (`btn_level`=1): if `s2`=0, go to RELEASE_WAIT and set `cnt`←1.
  - RELEASE_WAIT: if `s2`=1, return to PRESSED with no strobes. If `s2`=0 and `cnt`==`DEBOUNCE_CYCLES`, go to RELEASED, clear `btn_level` and pulse `btn_fall`. Otherwise increment `cnt`.
- A glitch shorter than `DEBOUNCE_CYCLES` samples never changes `btn_level` and never produces strobes.
- The two channels are fully independent. Simultaneous presses produce simultaneous strobes on the same cycle.
- `btn_rise` and `btn_fall` are registered and high for exactly one cycle. They are never both high on the same channel.
- Long-press detection uses a 25-bit counter `lcnt`:
  - `lcnt` clears while halt `btn_level`=0.
  - In PRESSED, `lcnt` increments each cycle.
  - When `lcnt` reaches `LONG_CYCLES`, `long_press` pulses once and `lcnt` saturates at that value. There is exactly one pulse per press, however long the button is held.
  - A RELEASE_WAIT bounce that returns to PRESSED does not clear `lcnt`.
- Reset (`rst_n`=0 sampled on a clock edge):
  - All FSMs go to RELEASED; `s1`, `s2`, `cnt` and `lcnt` are cleared.
  - Every output is 0 on the cycle after reset.
  - A button held through reset release is treated as a new press. It produces `btn_rise` after the normal latency.
  - Reset asserted mid-debounce discards the pending transition.

## Timing
- Press latency: raw input stable high before edge N gives `btn_level`=1 and `btn_rise`=1 after edge N+2+`DEBOUNCE_CYCLES`. This is 2 synchronizer cycles plus `DEBOUNCE_CYCLES` samples.
- Release latency is identical: `btn_fall` and `btn_level`=0 appear after edge N+2+`DEBOUNCE_CYCLES`.
- `long_press` fires `LONG_CYCLES` cycles after the `btn_rise` cycle of the halt channel.
- Throughput: there is no dead time. A new transition may begin the cycle after a strobe.

## Configuration
- `BUTTON_LONG_PRESS_EN` defined: `lcnt` and the long-press logic are built as described above.
- `BUTTON_LONG_PRESS_EN` undefined: `long_press` is tied to constant 0 and no long-press counter is instantiated. `LONG_CYCLES` is ignored.

## Test plan
Run with `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20, and `BUTTON_LONG_PRESS_EN` defined unless noted.
- Clean press: `btn_raw[0]` goes 0→1 before edge 10 and is held → `btn_rise[0]`=1 and `btn_level[0]`=1 after edge 16. `btn_rise[0]` is 0 again after edge 17. Channel 1 outputs stay 0.
- Glitch rejection: `btn_raw[1]`=1 for 3 cycles, then 0 → `btn_level[1]`, `btn_rise[1]` and `btn_fall[1]` stay 0 throughout.
- Bouncy release: channel 0 is pressed, then `btn_raw[0]` toggles 1,0,1,0 at 1-cycle spacing, then stays 0 → exactly one `btn_fall[0]`, 6 cycles after the final 1→0 edge, and no extra `btn_rise[0]`.
- Simultaneous presses: both bits rise on the same cycle → `btn_rise`=2'b11 on a single cycle.
- Long press: halt held 40 cycles → exactly one `long_press` pulse, 20 cycles after `btn_rise[1]`. Rebuilding with the macro undefined gives `long_press`=0 for the whole run.
- Reset mid-operation: `rst_n`=0 for 2 cycles during PRESS_WAIT with `btn_raw[0]` held → all outputs 0 the cycle after reset is sampled. `btn_rise[0]` then occurs 6 cycles after `rst_n` returns high.

Source files
------------

// File: rtl/button_conditioner_if.sv
// Button bundle between the raw pin front end and its consumers.
// The slave modport is the conditioner's side of the bundle.
interface button_conditioner_if #(
    parameter int NUM_LANES = 2
);
    logic [NUM_LANES-1:0] btn_raw;
    logic [NUM_LANES-1:0] btn_level;
    logic [NUM_LANES-1:0] btn_rise;
    logic [NUM_LANES-1:0] btn_fall;
    logic                 long_press;

    modport master (
        output btn_raw,
        input  btn_level, btn_rise, btn_fall, long_press
    );

    modport slave (
        input  btn_raw,
        output btn_level, btn_rise, btn_fall, long_press
    );
endinterface

// File: rtl/button_conditioner.sv
// Debounces the jump/halt buttons and emits press/release strobes; the halt
// long-press detector is built only when BUTTON_LONG_PRESS_EN is defined.
module btn_chan #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic pressed
);
    localparam logic [1:0] RELEASED     = 2'b00;
    localparam logic [1:0] PRESS_WAIT   = 2'b01;
    localparam logic [1:0] PRESSED      = 2'b10;
    localparam logic [1:0] RELEASE_WAIT = 2'b11;
    localparam logic [19:0] DB_MAX = 20'(DEBOUNCE_CYCLES);

    logic [1:0]  sync_pipe;  // [0]=s1, [1]=s2
    logic [1:0]  state;
    logic [19:0] cnt;
    logic        s2;

    assign s2      = sync_pipe[1];
    // Encoding puts the debounced level in the top state bit.
    assign level   = state[1];
    assign pressed = (state == PRESSED);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_pipe <= '0;
            state     <= RELEASED;
            cnt       <= '0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[0], raw};
            rise      <= 1'b0;
            fall      <= 1'b0;
            case (state)
                RELEASED: begin
                    if (s2) begin
                        state <= PRESS_WAIT;
                        cnt   <= 20'd1;
                    end
                end
                PRESS_WAIT: begin
                    if (!s2) begin
                        state <= RELEASED;
                    end else if (cnt == DB_MAX) begin
                        state <= PRESSED;
                        rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                PRESSED: begin
                    if (!s2) begin
                        state <= RELEASE_WAIT;
                        cnt   <= 20'd1;
                    end
                end
                default: begin
                    if (s2) begin
                        state <= PRESSED;
                    end else if (cnt == DB_MAX) begin
                        state <= RELEASED;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
            endcase
        end
    end
endmodule

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LONG_CYCLES     = 25000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    button_conditioner_if.slave   btn
);
    localparam int NUM_LANES = 2;
    localparam int HALT      = 1;

    logic [NUM_LANES-1:0] raw, level, rise, fall, pressed;

    assign raw = btn.btn_raw;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        btn_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (raw[i]),
            .level  (level[i]),
            .rise   (rise[i]),
            .fall   (fall[i]),
            .pressed(pressed[i])
        );
    end

    assign btn.btn_level = level;
    assign btn.btn_rise  = rise;
    assign btn.btn_fall  = fall;

`ifdef BUTTON_LONG_PRESS_EN
    localparam logic [24:0] LONG_MAX = 25'(LONG_CYCLES);

    logic [24:0] lcnt;
    logic        long_q;
    logic        unused_press;

    assign unused_press   = pressed[0];
    assign btn.long_press = long_q;

    // Counts only in steady PRESSED; a release bounce holds the count, and
    // saturation at LONG_MAX gives a single pulse per press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lcnt   <= '0;
            long_q <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (!level[HALT]) begin
                lcnt <= '0;
            end else if (pressed[HALT] && lcnt != LONG_MAX) begin
                lcnt   <= lcnt + 25'd1;
                long_q <= (lcnt + 25'd1 == LONG_MAX);
            end
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg     = ^{pressed, LONG_CYCLES};
    assign btn.long_press = 1'b0;
`endif
endmodule

// File: tb/tb_button_conditioner.sv
// Randomised scoreboard bench for button_conditioner with directed timing checks.
module tb_button_conditioner;
    localparam int D = 4;
    localparam int L = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    button_conditioner_if bus ();

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (bus)
    );

    typedef struct packed {
        logic [1:0] level;
        logic [1:0] rise;
        logic [1:0] fall;
        logic       lp;
    } out_t;

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rise_cnt0 = 0, rise_cnt1 = 0, fall_cnt0 = 0, fall_cnt1 = 0, lp_cnt = 0;

    // Reference: the debouncer sees each raw sample two edges late; a level
    // flips when D+1 consecutive seen samples disagree with it.
    logic [1:0] m_pipe[$];
    logic [1:0] m_lvl;
    int         m_run[2];
    int         m_lc;
    logic [1:0] m_seen;
    logic       m_held, m_halt_lvl;
    out_t       m_e;

    always @(posedge clk) begin
        m_e = '0;
        if (!rst_n) begin
            m_pipe = '{2'b00, 2'b00};
            m_lvl  = 2'b00;
            m_run  = '{0, 0};
            m_lc   = 0;
        end else begin
            m_seen = m_pipe.pop_front();
            m_pipe.push_back(bus.btn_raw);
            m_halt_lvl = m_lvl[1];
            m_held     = m_lvl[1] && (m_run[1] == 0);
            for (int ch = 0; ch < 2; ch++) begin
                if (m_seen[ch] != m_lvl[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == D + 1) begin
                        m_lvl[ch] = m_seen[ch];
                        m_run[ch] = 0;
                        if (m_seen[ch]) m_e.rise[ch] = 1'b1;
                        else            m_e.fall[ch] = 1'b1;
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end
            if (!m_halt_lvl) m_lc = 0;
            else if (m_held && m_lc < L) begin
                m_lc++;
                if (m_lc == L) m_e.lp = 1'b1;
            end
        end
        m_e.level = m_lvl;
`ifndef BUTTON_LONG_PRESS_EN
        m_e.lp = 1'b0;
`endif
        exp_q.push_back(m_e);
    end

    // Monitor: pops one expectation per edge and compares the whole output set.
    out_t got;
    out_t want;
    always @(negedge clk) begin
        cyc++;
        got = {bus.btn_level, bus.btn_rise, bus.btn_fall, bus.long_press};
        rise_cnt0 += int'(got.rise[0]);
        rise_cnt1 += int'(got.rise[1]);
        fall_cnt0 += int'(got.fall[0]);
        fall_cnt1 += int'(got.fall[1]);
        lp_cnt    += int'(got.lp);
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL scoreboard cycle %0d: got lvl=%b rise=%b fall=%b lp=%b, exp lvl=%b rise=%b fall=%b lp=%b",
                         cyc, got.level, got.rise, got.fall, got.lp,
                         want.level, want.rise, want.fall, want.lp);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, exp %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int r0, r1, f0, f1, l0;

    initial begin
        bus.btn_raw = 2'b00;
        rst_n = 1'b0;
        tick(3);
        chk("reset_outputs", int'({bus.btn_level, bus.btn_rise, bus.btn_fall, bus.long_press}), 0);
        rst_n = 1'b1;
        tick(2);

        // Clean press on jump: rise on the 7th edge after the raw change.
        bus.btn_raw[0] = 1'b1;
        tick(6);
        chk("press_early", int'(bus.btn_rise[0]), 0);
        tick(1);
        chk("press_rise", int'(bus.btn_rise), 1);
        chk("press_level", int'(bus.btn_level), 1);
        tick(1);
        chk("press_rise_one_cycle", int'(bus.btn_rise), 0);
        tick(4);

        // Glitch on halt shorter than the debounce window.
        r1 = rise_cnt1; f1 = fall_cnt1;
        bus.btn_raw[1] = 1'b1;
        tick(3);
        bus.btn_raw[1] = 1'b0;
        tick(12);
        chk("glitch_rise", rise_cnt1 - r1, 0);
        chk("glitch_fall", fall_cnt1 - f1, 0);
        chk("glitch_level", int'(bus.btn_level[1]), 0);

        // Bouncy release of jump.
        r0 = rise_cnt0; f0 = fall_cnt0;
        bus.btn_raw[0] = 1'b0; tick(1);
        bus.btn_raw[0] = 1'b1; tick(1);
        bus.btn_raw[0] = 1'b0; tick(1);
        bus.btn_raw[0] = 1'b1; tick(1);
        bus.btn_raw[0] = 1'b0;
        tick(7);
        chk("bounce_fall_time", int'(bus.btn_fall[0]), 1);
        tick(8);
        chk("bounce_fall_count", fall_cnt0 - f0, 1);
        chk("bounce_no_rise", rise_cnt0 - r0, 0);

        // Simultaneous presses.
        bus.btn_raw = 2'b11;
        tick(7);
        chk("simul_rise", int'(bus.btn_rise), 3);
        bus.btn_raw = 2'b00;
        tick(12);

        // Long press on halt.
        l0 = lp_cnt;
        bus.btn_raw[1] = 1'b1;
        tick(40);
        bus.btn_raw[1] = 1'b0;
        tick(12);
`ifdef BUTTON_LONG_PRESS_EN
        chk("long_press_count", lp_cnt - l0, 1);
`else
        chk("long_press_count", lp_cnt - l0, 0);
`endif

        // Reset during PRESS_WAIT with jump held.
        bus.btn_raw[0] = 1'b1;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        chk("midreset_outputs", int'({bus.btn_level, bus.btn_rise, bus.btn_fall, bus.long_press}), 0);
        tick(1);
        rst_n = 1'b1;
        tick(6);
        chk("midreset_early", int'(bus.btn_rise[0]), 0);
        tick(1);
        chk("midreset_rise", int'(bus.btn_rise[0]), 1);
        bus.btn_raw = 2'b00;
        tick(10);

        // Random bouncing with rare resets.
        for (int i = 0; i < 3000; i++) begin
            for (int ch = 0; ch < 2; ch++)
                if ($urandom_range(0, 9) == 0) bus.btn_raw[ch] = ~bus.btn_raw[ch];
            rst_n = ($urandom_range(0, 599) != 0);
            tick(1);
        end
        rst_n = 1'b1;
        bus.btn_raw = 2'b00;
        tick(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
